// File: rtl/apb_timer_pkg.sv
// Shared register map and bit positions for the APB timer peripheral.
package apb_timer_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_WIDTH    = 3;

    localparam int unsigned STATUS_MATCH = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: pulses tick once every divisor+1 enabled clocks.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        clear,
    input  logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == divisor);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// APB-attached 32-bit timer: one-wait-state bus slave, prescaled counter,
// compare match with one-shot/periodic behaviour and a registered level irq.
module apb_timer #(
    parameter int unsigned AWIDTH = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic              PREADY,
    output logic [31:0]       PRDATA,
    output logic              PSLVERROR,
    output logic              irq
);
    import apb_timer_pkg::*;

    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [15:0]           prescale_q, prescale_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic                  pready_q, pready_d;
    logic [31:0]           prdata_q, prdata_d;
    logic                  pslverror_q, pslverror_d;
    logic                  irq_q, irq_d;

    logic       access, mapped, wr_en;
    logic       wr_ctrl, wr_prescale, wr_count, wr_compare, wr_status;
    logic [2:0] reg_idx;
    logic       tick, match_hit;
    logic [31:0] rdata;
    logic       unused_paddr;

    assign unused_paddr = ^PADDR;

    assign access      = PSEL && PENABLE && !pready_q;
    assign reg_idx     = PADDR[4:2];
    assign mapped      = (reg_idx <= REG_STATUS);
    assign wr_en       = access && PWRITE && mapped;
    assign wr_ctrl     = wr_en && (reg_idx == REG_CTRL);
    assign wr_prescale = wr_en && (reg_idx == REG_PRESCALE);
    assign wr_count    = wr_en && (reg_idx == REG_COUNT);
    assign wr_compare  = wr_en && (reg_idx == REG_COMPARE);
    assign wr_status   = wr_en && (reg_idx == REG_STATUS);
    assign match_hit   = tick && (count_q == compare_q);

    timer_prescaler u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (ctrl_q[CTRL_EN]),
        .clear   (wr_prescale || wr_count),
        .divisor (prescale_q),
        .tick    (tick)
    );

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:     rdata = {{(32-CTRL_WIDTH){1'b0}}, ctrl_q};
            REG_PRESCALE: rdata = {16'd0, prescale_q};
            REG_COUNT:    rdata = count_q;
            REG_COMPARE:  rdata = compare_q;
            REG_STATUS:   rdata = {31'd0, match_q};
            default:      rdata = '0;
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        match_d    = match_q;

        if (tick) begin
            if (match_hit) begin
                if (ctrl_q[CTRL_PERIODIC]) begin
                    count_d = '0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // Bus writes are applied last so they win over same-cycle tick effects;
        // a tick's MATCH set is applied after W1C so it wins over the clear.
        if (wr_status && PWDATA[STATUS_MATCH]) match_d = 1'b0;
        if (match_hit)   match_d    = 1'b1;
        if (wr_ctrl)     ctrl_d     = PWDATA[CTRL_WIDTH-1:0];
        if (wr_prescale) prescale_d = PWDATA[15:0];
        if (wr_count)    count_d    = PWDATA;
        if (wr_compare)  compare_d  = PWDATA;
    end

    always_comb begin
        pready_d    = access;
        prdata_d    = access ? rdata : prdata_q;
        pslverror_d = access ? !mapped : pslverror_q;
        irq_d       = match_q && ctrl_q[CTRL_IRQ_EN];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            match_q     <= 1'b0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverror_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            match_q     <= match_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverror_q <= pslverror_d;
            irq_q       <= irq_d;
        end
    end

    assign PREADY    = pready_q;
    assign PRDATA    = prdata_q;
    assign PSLVERROR = pslverror_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: per-cycle comparison against a behavioural model,
// directed scenarios with hand-computed expectations, then random bus traffic.
module tb_apb_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  PADDR = '0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERROR;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    apb_timer #(.AWIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERROR (PSLVERROR),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_en = 0, m_per = 0, m_ie = 0, m_match = 0, m_irq = 0;
    bit          m_ready = 0, m_err = 0;
    logic [31:0] m_rd = '0, m_cnt = '0, m_cmp = '0;
    int unsigned m_psc = 0, m_elapsed = 0;

    function automatic logic [31:0] mread(input int unsigned idx);
        case (idx)
            0: return {29'd0, m_ie, m_per, m_en};
            1: return m_psc;
            2: return m_cnt;
            3: return m_cmp;
            4: return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit acc, wr, tick;
        int unsigned idx;
        if (!reset_n) begin
            m_en = 0; m_per = 0; m_ie = 0; m_match = 0; m_irq = 0;
            m_ready = 0; m_err = 0; m_rd = '0; m_cnt = '0; m_cmp = '0;
            m_psc = 0; m_elapsed = 0;
            return;
        end
        acc  = PSEL && PENABLE && !m_ready;
        idx  = PADDR[4:2];
        wr   = acc && PWRITE && (idx < 5);
        // a tick is due when the current period of psc+1 enabled clocks completes
        tick = m_en && (m_elapsed + 1 == m_psc + 1);
        m_irq   = m_match && m_ie;
        m_ready = acc;
        if (acc) begin
            m_err = (idx >= 5);
            m_rd  = mread(idx);
        end
        if (wr && (idx == 1 || idx == 2)) m_elapsed = 0;
        else if (tick)                    m_elapsed = 0;
        else if (m_en)                    m_elapsed = m_elapsed + 1;
        if (wr && idx == 4 && PWDATA[0]) m_match = 0;
        if (tick) begin
            if (m_cnt == m_cmp) begin
                m_match = 1;
                if (m_per) m_cnt = '0;
                else       m_en = 0;
            end else begin
                m_cnt = 32'((64'(m_cnt) + 1) % 64'h1_0000_0000);
            end
        end
        if (wr) begin
            case (idx)
                0: begin m_en = PWDATA[0]; m_per = PWDATA[1]; m_ie = PWDATA[2]; end
                1: m_psc = PWDATA[15:0];
                2: m_cnt = PWDATA;
                3: m_cmp = PWDATA;
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (checking) begin
            chk("pready", 32'(PREADY), 32'(m_ready));
            chk("irq", 32'(irq), 32'(m_irq));
            if (m_ready) begin
                chk("prdata", PRDATA, m_rd);
                chk("pslverror", 32'(PSLVERROR), 32'(m_err));
            end
        end
    end

    // ---------------- bus helpers ----------------
    task automatic apb(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err, output int waits);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge clk);
        PENABLE = 1'b1;
        waits = 1;
        rd = 'x;
        err = 1'b1;
        while (waits < 8) begin
            @(negedge clk);
            waits++;
            if (PREADY) break;
        end
        if (!PREADY) chk("pready_timeout", 32'(waits), 32'd2);
        rd  = PRDATA;
        err = PSLVERROR;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] rd; bit err; int waits;
        apb(1'b1, addr, wd, rd, err, waits);
    endtask

    task automatic rd_reg(input string nm, input logic [7:0] addr,
                          input logic [31:0] exp, input bit exp_err);
        logic [31:0] rd; bit err; int waits;
        apb(1'b0, addr, '0, rd, err, waits);
        chk({nm, "_data"}, rd, exp);
        chk({nm, "_err"}, 32'(err), 32'(exp_err));
    endtask

    // counts falling edges until irq reaches the given level
    task automatic wait_irq(input string nm, input bit level, input int exp_n);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (irq == level) break;
        end
        chk(nm, 32'(n), 32'(exp_n));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        bit err;
        int waits;

        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        checking = 1'b1;

        // reset state: every register zero, two-cycle completion
        chk("reset_irq", 32'(irq), 32'd0);
        for (int i = 0; i < 5; i++) begin
            apb(1'b0, 8'(i * 4), '0, rd, err, waits);
            chk("reset_rd_data", rd, 32'd0);
            chk("reset_rd_err", 32'(err), 32'd0);
            chk("reset_rd_waits", 32'(waits), 32'd2);
        end

        // one-shot: 6 ticks of 4 clocks, irq one clock after MATCH
        wr_reg(8'h04, 32'd3);
        wr_reg(8'h0C, 32'd5);
        wr_reg(8'h00, 32'h5);
        wait_irq("oneshot_irq_delay", 1'b1, 25);
        idle(10);
        rd_reg("oneshot_count", 8'h08, 32'd5, 1'b0);
        rd_reg("oneshot_ctrl", 8'h00, 32'h4, 1'b0);
        rd_reg("oneshot_status", 8'h10, 32'h1, 1'b0);

        // periodic
        wr_reg(8'h10, 32'h1);
        wr_reg(8'h08, 32'd0);
        wr_reg(8'h00, 32'h7);
        wait_irq("periodic_irq_delay", 1'b1, 25);
        wr_reg(8'h10, 32'h1);
        wait_irq("w1c_irq_drop", 1'b0, 1);
        idle(60);
        wr_reg(8'h00, 32'h0);
        wr_reg(8'h10, 32'h1);

        // wrap: FFFFFFFE -> FFFFFFFF -> 0 ... match on tick 19
        wr_reg(8'h04, 32'd0);
        wr_reg(8'h0C, 32'h10);
        wr_reg(8'h08, 32'hFFFF_FFFE);
        wr_reg(8'h00, 32'h5);
        wait_irq("wrap_irq_delay", 1'b1, 20);
        rd_reg("wrap_count", 8'h08, 32'h10, 1'b0);

        // unmapped addresses
        rd_reg("unmapped_rd14", 8'h14, 32'd0, 1'b1);
        apb(1'b1, 8'h1C, 32'hFFFF_FFFF, rd, err, waits);
        chk("unmapped_wr1c_err", 32'(err), 32'd1);
        chk("unmapped_wr1c_data", rd, 32'd0);
        rd_reg("unmapped_rd1c", 8'h1C, 32'd0, 1'b1);
        rd_reg("after_unmapped_compare", 8'h0C, 32'h10, 1'b0);
        rd_reg("upper_addr_ignored", 8'hEC, 32'h10, 1'b0);

        // COUNT written while ticking every clock: the written value wins
        wr_reg(8'h00, 32'h0);
        wr_reg(8'h10, 32'h1);
        wr_reg(8'h0C, 32'h1234);
        wr_reg(8'h08, 32'd0);
        wr_reg(8'h00, 32'h1);
        wr_reg(8'h08, 32'h1234);
        idle(3);
        rd_reg("count_write_wins", 8'h08, 32'h1234, 1'b0);
        rd_reg("count_write_oneshot_ctrl", 8'h00, 32'h0, 1'b0);

        // reset during the access cycle of a COMPARE write
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'hAA;
        @(negedge clk);
        PENABLE = 1'b1;
        #2 reset_n = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        rd_reg("reset_abort_compare", 8'h0C, 32'd0, 1'b0);

        // randomized traffic, checked cycle by cycle against the model
        for (int t = 0; t < 400; t++) begin
            int unsigned idx;
            logic [31:0] wd;
            logic [7:0]  addr;
            idx  = $urandom_range(0, 7);
            addr = {3'($urandom_range(0, 7)), 3'(idx), 2'($urandom_range(0, 3))};
            case (idx)
                0: wd = $urandom_range(0, 7);
                1: wd = $urandom_range(0, 3);
                2: wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD + $urandom_range(0, 2)
                                                    : 32'($urandom_range(0, 8));
                3: wd = $urandom_range(0, 8);
                4: wd = $urandom_range(0, 1);
                default: wd = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = wd;
                @(negedge clk);
                PSEL = 1'b0;
            end else begin
                apb(1'($urandom_range(0, 1)), addr, wd, rd, err, waits);
                chk("rand_waits", 32'(waits), 32'd2);
            end
            idle($urandom_range(0, 6));
        end

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
